// File: rtl/fpadd_seq_arb.sv
// rtl/fpadd_seq_arb.sv - sequencer and two-port round-robin arbiter for the shared FP adder datapath
//
// Purpose: accepts operand pairs from two requesters, drives the granted pair onto the
// fpbus A/B inputs, walks a one-hot strobe through the five datapath stages
// (mask, align, alu, normal, pack) and returns the captured Result tagged with the owner.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid[1:0]/req_ready   per-requester handshake; req_ready is at most one-hot
//   req_a0/req_b0, req_a1/b1   IEEE-754 single operands for requester 0 / 1
//   bus_a, bus_b               held operands driven to the datapath
//   bus_result                 datapath sum
//   stage_en[4:0]              one-hot stage strobe, 0 when not evaluating
//   resp_valid/resp_ready      response handshake
//   resp_result, resp_id       captured sum and owning requester
//   busy                       high whenever not idle
module fpadd_seq_arb #(
   parameter int unsigned STAGE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   output logic [31:0] bus_a,
   output logic [31:0] bus_b,
   input  logic [31:0] bus_result,
   output logic [4:0]  stage_en,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_id,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_RESP} state_t;

   localparam logic [3:0] CNT_LAST = 4'(STAGE_CYCLES - 1);

   state_t      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  stage_idx_q, stage_idx_d;
   logic [31:0] bus_a_q, bus_a_d;
   logic [31:0] bus_b_q, bus_b_d;
   logic [31:0] resp_result_q, resp_result_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_id_q, resp_id_d;

   logic        grant_any;
   logic        grant_sel;

   // Round-robin pick: a lone requester always wins; on a tie the one that
   // did not win last time is chosen.
   always_comb begin
      grant_any = 1'b0;
      grant_sel = 1'b0;
      case (req_valid)
         2'b01: begin grant_any = 1'b1; grant_sel = 1'b0;          end
         2'b10: begin grant_any = 1'b1; grant_sel = 1'b1;          end
         2'b11: begin grant_any = 1'b1; grant_sel = ~last_grant_q; end
         default: ;
      endcase
   end

   // Gated by reset so nothing looks accepted on a cycle that is being reset.
   always_comb begin
      req_ready = 2'b00;
      if (state_q == ST_IDLE && !reset && grant_any)
         req_ready = grant_sel ? 2'b10 : 2'b01;
   end

   always_comb begin
      stage_en = 5'b00000;
      if (state_q == ST_EVAL && stage_idx_q <= 3'd4)
         stage_en = 5'b00001 << stage_idx_q;
   end

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      cnt_d         = cnt_q;
      stage_idx_d   = stage_idx_q;
      bus_a_d       = bus_a_q;
      bus_b_d       = bus_b_q;
      resp_result_d = resp_result_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      case (state_q)
         ST_IDLE: begin
            if (req_ready != 2'b00) begin
               bus_a_d      = grant_sel ? req_a1 : req_a0;
               bus_b_d      = grant_sel ? req_b1 : req_b0;
               resp_id_d    = grant_sel;
               last_grant_d = grant_sel;
               cnt_d        = 4'd0;
               stage_idx_d  = 3'd0;
               state_d      = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (stage_idx_q > 3'd4) begin
               // Unreachable index: bail out rather than strobe a nonexistent stage.
               stage_idx_d = 3'd0;
               cnt_d       = 4'd0;
               state_d     = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = 4'd0;
               if (stage_idx_q == 3'd4) begin
                  resp_result_d = bus_result;
                  resp_valid_d  = 1'b1;
                  state_d       = ST_RESP;
               end else begin
                  stage_idx_d = stage_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            // Returning to IDLE here means the handshake cycle never accepts.
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         cnt_q         <= 4'd0;
         stage_idx_q   <= 3'd0;
         bus_a_q       <= 32'd0;
         bus_b_q       <= 32'd0;
         resp_result_q <= 32'd0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         stage_idx_q   <= stage_idx_d;
         bus_a_q       <= bus_a_d;
         bus_b_q       <= bus_b_d;
         resp_result_q <= resp_result_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
      end
   end

   assign bus_a       = bus_a_q;
   assign bus_b       = bus_b_q;
   assign resp_result = resp_result_q;
   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpadd_seq_arb.sv
// tb/tb_fpadd_seq_arb.sv - self-checking bench for fpadd_seq_arb
module tb_fpadd_seq_arb;

   localparam logic [31:0] ONE   = 32'h3F800000;
   localparam logic [31:0] TWO   = 32'h40000000;
   localparam logic [31:0] THREE = 32'h40400000;
   localparam logic [31:0] NTWO  = 32'hC0000000;
   localparam logic [31:0] PINF  = 32'h7F800000;
   localparam logic [31:0] NINF  = 32'hFF800000;
   localparam logic [31:0] QNAN  = 32'h7FC00000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;

   logic [1:0]  req_valid, req_ready;
   logic [31:0] bus_a, bus_b, bus_result, resp_result;
   logic [4:0]  stage_en;
   logic        resp_valid, resp_ready, resp_id, busy;

   logic [1:0]  req_valid3, req_ready3;
   logic [31:0] bus_a3, bus_b3, bus_result3, resp_result3;
   logic [4:0]  stage_en3;
   logic        resp_valid3, resp_ready3, resp_id3, busy3;

   // Stand-in for the fpbus datapath: known sums only.
   function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
      if (a == ONE  && b == TWO)  return THREE;
      if (a == ONE  && b == ONE)  return TWO;
      if (a == NTWO && b == TWO)  return 32'h00000000;
      if (a == PINF && b == NINF) return QNAN;
      return 32'hDEADBEEF;
   endfunction

   assign bus_result  = fp_model(bus_a, bus_b);
   assign bus_result3 = fp_model(bus_a3, bus_b3);

   fpadd_seq_arb #(.STAGE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .bus_a(bus_a), .bus_b(bus_b), .bus_result(bus_result), .stage_en(stage_en),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .resp_id(resp_id), .busy(busy)
   );

   fpadd_seq_arb #(.STAGE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .bus_a(bus_a3), .bus_b(bus_b3), .bus_result(bus_result3), .stage_en(stage_en3),
      .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_result(resp_result3),
      .resp_id(resp_id3), .busy(busy3)
   );

   typedef struct {
      bit          rst;
      logic [1:0]  valid;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  exp_rdy;
      logic        exp_id;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vecs [8];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One full S=1 transaction with resp_ready high; request stays asserted throughout.
   task automatic run_op(input vec_t v, input int idx);
      logic [31:0] ea, eb;
      logic [4:0]  es;
      req_a0 = v.a0; req_b0 = v.b0; req_a1 = v.a1; req_b1 = v.b1;
      req_valid  = v.valid;
      resp_ready = 1'b1;
      #1;
      chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.exp_rdy));
      ea = v.exp_id ? v.a1 : v.a0;
      eb = v.exp_id ? v.b1 : v.b0;
      step;
      for (int k = 0; k < 5; k++) begin
         es = 5'd1 << k;
         chk($sformatf("v%0d stage_en c%0d", idx, k + 1), 32'(stage_en), 32'(es));
         chk($sformatf("v%0d bus_a c%0d", idx, k + 1), bus_a, ea);
         chk($sformatf("v%0d bus_b c%0d", idx, k + 1), bus_b, eb);
         chk($sformatf("v%0d busy req_ready c%0d", idx, k + 1), 32'({busy, req_ready}), 32'd4);
         step;
      end
      chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d resp_result", idx), resp_result, v.exp_res);
      chk($sformatf("v%0d resp_id", idx), 32'(resp_id), 32'(v.exp_id));
      chk($sformatf("v%0d stage_en resp", idx), 32'(stage_en), 32'd0);
      step;
      chk($sformatf("v%0d idle resp_valid", idx), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d idle busy", idx), 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int       t;
      bit       seen;
      logic [4:0] es;

      reset = 1'b1;
      req_valid = 2'b00; req_valid3 = 2'b00;
      resp_ready = 1'b1; resp_ready3 = 1'b1;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

      vecs[0] = '{1'b0, 2'b01, ONE,  TWO,  32'd0, 32'd0, 2'b01, 1'b0, THREE};
      vecs[1] = '{1'b1, 2'b11, ONE,  ONE,  NTWO,  TWO,   2'b01, 1'b0, TWO};
      vecs[2] = '{1'b0, 2'b11, ONE,  ONE,  NTWO,  TWO,   2'b10, 1'b1, 32'd0};
      vecs[3] = '{1'b0, 2'b11, ONE,  ONE,  NTWO,  TWO,   2'b01, 1'b0, TWO};
      vecs[4] = '{1'b0, 2'b10, ONE,  ONE,  NTWO,  TWO,   2'b10, 1'b1, 32'd0};
      vecs[5] = '{1'b0, 2'b10, ONE,  ONE,  NTWO,  TWO,   2'b10, 1'b1, 32'd0};
      vecs[6] = '{1'b0, 2'b01, PINF, NINF, NTWO,  TWO,   2'b01, 1'b0, QNAN};
      vecs[7] = '{1'b0, 2'b11, ONE,  TWO,  ONE,   ONE,   2'b10, 1'b1, TWO};

      repeat (3) step;
      reset = 1'b0;
      #1;
      chk("rst req_ready",   32'(req_ready),   32'd0);
      chk("rst stage_en",    32'(stage_en),    32'd0);
      chk("rst resp_valid",  32'(resp_valid),  32'd0);
      chk("rst resp_id",     32'(resp_id),     32'd0);
      chk("rst busy",        32'(busy),        32'd0);
      chk("rst bus_a",       bus_a,            32'd0);
      chk("rst bus_b",       bus_b,            32'd0);
      chk("rst resp_result", resp_result,      32'd0);
      chk("rst busy3",       32'(busy3),       32'd0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].rst) begin
            reset = 1'b1; req_valid = 2'b00;
            step;
            reset = 1'b0;
         end
         run_op(vecs[i], i);
      end

      // Backpressure: hold the response for 10 cycles with both requesters pending.
      req_a0 = ONE; req_b0 = TWO; req_valid = 2'b01;
      #1;
      chk("bp accept req_ready", 32'(req_ready), 32'd1);
      step;
      resp_ready = 1'b0;
      repeat (5) step;
      req_a1 = ONE; req_b1 = ONE; req_valid = 2'b11;
      #1;
      for (int j = 0; j < 10; j++) begin
         chk($sformatf("bp c%0d resp_valid", j), 32'(resp_valid), 32'd1);
         chk($sformatf("bp c%0d resp_result", j), resp_result, THREE);
         chk($sformatf("bp c%0d resp_id", j), 32'(resp_id), 32'd0);
         chk($sformatf("bp c%0d req_ready", j), 32'(req_ready), 32'd0);
         step;
      end
      resp_ready = 1'b1;
      #1;
      chk("bp handshake req_ready", 32'(req_ready), 32'd0);
      step;
      chk("bp post resp_valid", 32'(resp_valid), 32'd0);
      chk("bp post req_ready",  32'(req_ready),  32'd2);
      step;
      req_valid = 2'b00;
      chk("bp next busy",    32'(busy),    32'd1);
      chk("bp next resp_id", 32'(resp_id), 32'd1);
      t = 0;
      while (!resp_valid && t < 20) begin
         step;
         t++;
      end
      chk("bp drain resp_valid",  32'(resp_valid), 32'd1);
      chk("bp drain resp_result", resp_result,     TWO);
      step;

      // Reset in the middle of an evaluation.
      req_a0 = ONE; req_b0 = TWO; req_valid = 2'b01;
      step;
      req_valid = 2'b00;
      step;
      step;
      chk("abort stage_en before", 32'(stage_en), 32'd4);
      reset = 1'b1;
      step;
      chk("abort stage_en",   32'(stage_en),   32'd0);
      chk("abort busy",       32'(busy),       32'd0);
      chk("abort bus_a",      bus_a,           32'd0);
      chk("abort resp_valid", 32'(resp_valid), 32'd0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         step;
         if (resp_valid) seen = 1'b1;
      end
      chk("abort no response", 32'(seen), 32'd0);

      // STAGE_CYCLES=3 instance.
      req_a0 = ONE; req_b0 = TWO; req_valid3 = 2'b01;
      #1;
      chk("s3 req_ready", 32'(req_ready3), 32'd1);
      step;
      req_valid3 = 2'b00;
      for (int c = 1; c <= 15; c++) begin
         es = 5'd1 << ((c - 1) / 3);
         chk($sformatf("s3 c%0d stage_en", c), 32'(stage_en3), 32'(es));
         chk($sformatf("s3 c%0d resp_valid", c), 32'(resp_valid3), 32'd0);
         chk($sformatf("s3 c%0d bus_a", c), bus_a3, ONE);
         step;
      end
      chk("s3 c16 resp_valid",  32'(resp_valid3), 32'd1);
      chk("s3 c16 resp_result", resp_result3,     THREE);
      chk("s3 c16 resp_id",     32'(resp_id3),    32'd0);
      step;
      chk("s3 idle busy", 32'(busy3), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fpadd_seq_arb.md
# fpadd_seq_arb

Sequencer and two-port arbiter for the shared single-precision FP adder datapath (mask → align → alu → normal → pack stages on the `fpbus` interface). Two requesters submit operand pairs with valid/ready handshakes. A round-robin arbiter grants one request at a time. The FSM holds the granted operands on the bus, steps a one-hot stage strobe through the five stages, captures `Result` and returns it with the requester ID. The block sits between the client ports and the `fpbus` instance, and it is the only driver of `A`/`B`.

## Interface
Parameters:
- `STAGE_CYCLES`, default 1: cycles each datapath stage is given to settle. Legal range is 1..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: single clock; all state updates on the rising edge.
  - `reset`, input, 1: synchronous, active-high reset.
- Request ports:
  - `req_valid`, input, 2: request valid; bit i belongs to requester i.
  - `req_ready`, output, 2: request accepted this cycle; at most one bit is high.
  - `req_a0`, `req_b0`, input, 32 each: requester 0 operands (IEEE-754 single).
  - `req_a1`, `req_b1`, input, 32 each: requester 1 operands.
- Datapath side:
  - `bus_a`, `bus_b`, output, 32 each: drive the `fpbus` `A`/`B`.
  - `bus_result`, input, 32: `fpbus` `Result`.
  - `stage_en`, output, 5: one-hot stage strobe; bit0 = mask … bit4 = pack; 0 when not evaluating.
- Response and status:
  - `resp_valid`, output, 1: result available.
  - `resp_ready`, input, 1: consumer accepts the result.
  - `resp_result`, output, 32: captured sum.
  - `resp_id`, output, 1: ID of the requester that owns `resp_result`.
  - `busy`, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, EVAL, RESP.
- IDLE:
  - `req_ready` is combinational from `req_valid` and `last_grant`.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester ≠ `last_grant` is granted.
  - On the accepting edge:
    - the selected operands are latched into `bus_a`/`bus_b`;
    - the owner is latched into `resp_id`;
    - `last_grant` is updated;
    - the FSM moves to EVAL with `stage_idx`=0 and `cnt`=0.
- EVAL:
  - `stage_en` = 1<<`stage_idx`.
  - `cnt` increments each cycle. When `cnt`==`STAGE_CYCLES`-1, `cnt` clears and `stage_idx` increments.
  - On the last cycle of `stage_idx`=4:
    - `bus_result` is registered into `resp_result`;
    - `resp_valid` is set;
    - the FSM moves to RESP.
- RESP:
  - `resp_valid` is held high and `resp_result`/`resp_id` are held stable until `resp_ready`=1.
  - On that handshake edge, `resp_valid` clears and the FSM moves to IDLE.
  - No new request is accepted in the handshake cycle.
- `bus_a`/`bus_b` hold the last accepted operands until the next accept. They are never changed during EVAL or RESP.
- `req_valid` asserted outside IDLE is ignored, with `req_ready`=0. The request stays pending and the requester must hold its operands.
- Counter widths: `cnt` is 4 bits; `stage_idx` is 3 bits.
- Values 5..7 of `stage_idx` are unreachable. If reached, the FSM returns to IDLE with `stage_en`=0.

## Timing
- Reset values:
  - state IDLE; `last_grant`=1, so requester 0 wins the first tie;
  - `req_ready`=0, `stage_en`=0, `resp_valid`=0, `resp_id`=0, `busy`=0;
  - `bus_a`=`bus_b`=`resp_result`=0.
- Reset asserted mid-EVAL or mid-RESP aborts the operation. No response is produced, and all outputs take their reset values on the next edge.
- Latency: accept at edge T; `stage_en` bit0 is high from T+1. `resp_valid` rises at T+1+5·`STAGE_CYCLES`, i.e. cycle 6 for S=1.
- Each `stage_en` bit is high for exactly `STAGE_CYCLES` consecutive cycles, with no gaps and no overlap.
- Minimum issue interval is 5·S+2 cycles when `resp_ready` is tied high.
- Back-to-back contention alternates grants 0,1,0,1,…. A lone requester is granted every time.
- `busy` is high from T+1 through the cycle of the response handshake.

## Test plan
- **Single add.** After reset, with S=1: `req_valid`=01, `req_a0`=0x3F800000, `req_b0`=0x40000000, `resp_ready`=1.
  - `req_ready`=01 in the accept cycle.
  - `stage_en` walks 1,2,4,8,16 over cycles 1–5.
  - `resp_valid`=1 at cycle 6 with `resp_result`=0x40400000 and `resp_id`=0.
- **Tie after reset.** Both requesters valid: 1.0+1.0 and 0xC0000000+0x40000000.
  - Requester 0 is granted first and returns 0x40000000, `resp_id`=0.
  - Requester 1 is granted next and returns 0x00000000, `resp_id`=1.
  - The third grant (both still valid) goes to 0.
- **Backpressure.** Hold `resp_ready`=0 for 10 cycles after `resp_valid` rises.
  - `resp_result`/`resp_id` stay stable; `req_ready`=00 throughout.
  - Acceptance resumes the cycle after the handshake, not in it.
- **Reset mid-op.** Assert `reset` during `stage_en`=00100.
  - Next cycle: `stage_en`=0, `busy`=0, `bus_a`=0.
  - No `resp_valid` ever appears for the aborted op.
- **STAGE_CYCLES=3.** Each `stage_en` bit is held 3 cycles; `resp_valid` appears 16 cycles after accept.
- **Special operands.** 0x7F800000 + 0xFF800000 returns whatever `bus_result` presents, which is NaN from the datapath. `bus_a`/`bus_b` are unchanged across all EVAL cycles.
